// File: rtl/simmem_pkg.sv
// Shared constants and response typedefs for the simulated-memory delay model.
package simmem_pkg;

  localparam int unsigned IDWidth    = 4;
  localparam int unsigned RespWidth  = 2;
  localparam int unsigned RDataWidth = 8;

  localparam int unsigned WRespBankCapacity = 32;
  localparam int unsigned RDataBankCapacity = 32;
  localparam int unsigned BankAddrWidth     = $clog2(RDataBankCapacity);

  // The ID sits in the low bits so banks can extract it without knowing the payload.
  typedef struct packed {
    logic [RespWidth-1:0] rsp;
    logic [IDWidth-1:0]   id;
  } wresp_t;

  typedef struct packed {
    logic [RDataWidth-1:0] data;
    logic [RespWidth-1:0]  rsp;
    logic [IDWidth-1:0]    id;
  } rdata_resp_t;

  localparam int unsigned WRespWidth     = $bits(wresp_t);
  localparam int unsigned RDataRespWidth = $bits(rdata_resp_t);

  typedef struct packed {
    logic [BankAddrWidth-1:0] next;
  } slot_meta_t;

endpackage

// File: rtl/simmem_id_arbiter.sv
// Picks one requesting ID: round-robin from start_ptr_i+1 when
// SIMMEM_RESP_BANK_ROUND_ROBIN_EN is defined, lowest ID first otherwise.
module simmem_id_arbiter #(
  parameter int unsigned NumIds  = 16,
  parameter int unsigned IdWidth = $clog2(NumIds)
) (
  input  logic [NumIds-1:0]  req_i,
  input  logic [IdWidth-1:0] start_ptr_i,
  output logic [NumIds-1:0]  grant_o,
  output logic [IdWidth-1:0] id_o
);

`ifdef SIMMEM_RESP_BANK_ROUND_ROBIN_EN
  logic [IdWidth-1:0] idx;

  // Walk backwards so the candidate closest after start_ptr_i is assigned last.
  always_comb begin
    id_o = '0;
    idx  = '0;
    for (int i = NumIds; i >= 1; i--) begin
      idx = start_ptr_i + IdWidth'(i);
      if (req_i[idx]) id_o = idx;
    end
  end
`else
  logic unused_start_ptr;
  assign unused_start_ptr = ^start_ptr_i;

  always_comb begin
    id_o = '0;
    for (int i = NumIds - 1; i >= 0; i--) begin
      if (req_i[i]) id_o = IdWidth'(i);
    end
  end
`endif

  assign grant_o = (|req_i) ? (NumIds'(1) << id_o) : '0;

endmodule

// File: rtl/simmem_resp_bank.sv
// Per-ID response bank: linked lists in a shared slot array, released per ID.
// Optional round-robin arbitration across IDs: SIMMEM_RESP_BANK_ROUND_ROBIN_EN.
module simmem_resp_bank
  import simmem_pkg::*;
#(
  parameter int unsigned DataWidth     = RDataRespWidth,
  parameter int unsigned IDWidth       = simmem_pkg::IDWidth,
  parameter int unsigned TotalCapacity = RDataBankCapacity,
  parameter int unsigned AddrWidth     = $clog2(TotalCapacity),
  localparam int unsigned NumIds       = 2**IDWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DataWidth-1:0] in_data_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [NumIds-1:0]    release_en_i,
  output logic [DataWidth-1:0] out_data_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [AddrWidth:0]   free_count_o
);

  logic [TotalCapacity-1:0] valid_q;
  logic [DataWidth-1:0]     data_q [TotalCapacity];
  logic [AddrWidth-1:0]     next_q [TotalCapacity];
  logic [AddrWidth-1:0]     head_q [NumIds];
  logic [AddrWidth-1:0]     tail_q [NumIds];
  logic [NumIds-1:0]        nonempty_q;
  logic                     locked_q;
  logic [IDWidth-1:0]       locked_id_q;

  logic [AddrWidth-1:0] alloc_idx;
  logic [AddrWidth:0]   free_cnt;
  logic [NumIds-1:0]    eligible, grant;
  logic [IDWidth-1:0]   arb_id, sel_id, in_id, start_ptr;
  logic [AddrWidth-1:0] head_sel;
  logic                 in_hs, out_hs, pop_last, restart;

  always_comb begin
    alloc_idx = '0;
    for (int i = TotalCapacity - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_idx = AddrWidth'(i);
    end
  end

  always_comb begin
    free_cnt = (AddrWidth + 1)'(TotalCapacity);
    for (int i = 0; i < TotalCapacity; i++) begin
      if (valid_q[i]) free_cnt = free_cnt - (AddrWidth + 1)'(1);
    end
  end

  assign free_count_o = free_cnt;
  assign in_ready_o   = rst_ni & ~(&valid_q);
  assign eligible     = nonempty_q & release_en_i;

`ifdef SIMMEM_RESP_BANK_ROUND_ROBIN_EN
  logic [IDWidth-1:0] rr_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q <= '1;
    end else if (out_hs) begin
      rr_q <= sel_id;
    end
  end

  assign start_ptr = rr_q;
`else
  assign start_ptr = '1;
`endif

  simmem_id_arbiter #(
    .NumIds  (NumIds),
    .IdWidth (IDWidth)
  ) u_arbiter (
    .req_i       (eligible),
    .start_ptr_i (start_ptr),
    .grant_o     (grant),
    .id_o        (arb_id)
  );

  logic unused_grant;
  assign unused_grant = ^grant;

  // A stalled output keeps its ID so data stays stable even if release_en_i drops.
  assign sel_id      = locked_q ? locked_id_q : arb_id;
  assign head_sel    = head_q[sel_id];
  assign out_valid_o = rst_ni & (locked_q | (|eligible));
  assign out_data_o  = data_q[head_sel];

  assign in_id    = in_data_i[IDWidth-1:0];
  assign in_hs    = in_valid_i & in_ready_o;
  assign out_hs   = out_valid_o & out_ready_i;
  assign pop_last = out_hs & (head_sel == tail_q[sel_id]);
  // Pushing onto a list that is empty or being emptied this cycle starts it afresh.
  assign restart  = ~nonempty_q[in_id] | (pop_last & (sel_id == in_id));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      valid_q     <= '0;
      nonempty_q  <= '0;
      locked_q    <= 1'b0;
      locked_id_q <= '0;
    end else begin
      if (out_hs) begin
        valid_q[head_sel] <= 1'b0;
        if (pop_last) nonempty_q[sel_id] <= 1'b0;
      end
      if (in_hs) begin
        valid_q[alloc_idx] <= 1'b1;
        nonempty_q[in_id]  <= 1'b1;
      end
      if (out_hs) begin
        locked_q <= 1'b0;
      end else if (out_valid_o) begin
        locked_q    <= 1'b1;
        locked_id_q <= sel_id;
      end
    end
  end

  // Payload and list pointers are only meaningful under the valid/nonempty flags.
  always_ff @(posedge clk_i) begin
    if (out_hs && !pop_last) head_q[sel_id] <= next_q[head_sel];
    if (in_hs) begin
      data_q[alloc_idx] <= in_data_i;
      tail_q[in_id]     <= alloc_idx;
      if (restart) begin
        head_q[in_id] <= alloc_idx;
      end else begin
        next_q[tail_q[in_id]] <= alloc_idx;
      end
    end
  end

endmodule
